// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: shifter states,
// register map and CTRL field layout.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_DONE
  } tx_state_e;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_CTRL   = 2'd1;
  localparam logic [1:0] ADR_DIV_LO = 2'd2;
  localparam logic [1:0] ADR_DIV_HI = 2'd3;

  localparam int CTRL_PAR_LSB = 0;
  localparam int CTRL_STOP2   = 2;
  localparam int CTRL_INT_DIS = 3;
  localparam int CTRL_OVF_CLR = 7;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Register bus between the system bus master and the UART transmitter.
interface uart_tx_fifo_if;
  logic [1:0] i_adr;
  logic [7:0] i_dat;
  logic [7:0] o_dat;
  logic       i_we;
  logic       i_cyc;

  modport master (output i_adr, i_dat, i_we, i_cyc, input o_dat);
  modport slave  (input i_adr, i_dat, i_we, i_cyc, output o_dat);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary pointers and an occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a push into a full
  // FIFO is refused even if a pop happens in the same cycle.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bus-writable byte queue feeding a frame shifter
// with programmable divisor, parity and stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int SYS_CLK    = 25_000_000,
  parameter int BAUDRATE   = 115_200,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_tx_fifo_if.slave  bus,
  output logic           tx,
  output logic           o_int
);
  localparam int DIV_RST = SYS_CLK / BAUDRATE - 1;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       par_q, par_d;
  logic             stop2_q, stop2_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       ctrl_q, ctrl_d;
  logic             ovf_q, ovf_d;

  logic             wr_en, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic             tick, busy;
  logic [7:0]       fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic [15:0]      div16, div16_new;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.i_dat),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wr_en     = bus.i_cyc & bus.i_we;
  assign fifo_push = wr_en && (bus.i_adr == ADR_DATA);
  assign tick      = (baud_cnt_q == div_sh_q);
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
  assign div16     = 16'(div_q);
  assign o_int     = (state_q == ST_DONE) && fifo_empty && !ctrl_q[CTRL_INT_DIS];

  // Register file: CTRL, divisor and the sticky overflow flag.
  always_comb begin
    ctrl_d    = ctrl_q;
    ovf_d     = ovf_q;
    div16_new = div16;
    if (wr_en) begin
      case (bus.i_adr)
        ADR_DATA:   if (fifo_full) ovf_d = 1'b1;
        ADR_CTRL: begin
          ctrl_d = bus.i_dat[6:0];
          if (bus.i_dat[CTRL_OVF_CLR]) ovf_d = 1'b0;
        end
        ADR_DIV_LO: div16_new[7:0]  = bus.i_dat;
        default:    div16_new[15:8] = bus.i_dat;
      endcase
    end
    div_d = DIV_W'(div16_new);
  end

  always_comb begin
    case (bus.i_adr)
      ADR_DATA:   bus.o_dat = {4'b0, ovf_q, fifo_empty, fifo_full, busy};
      ADR_CTRL:   bus.o_dat = {1'b0, ctrl_q};
      ADR_DIV_LO: bus.o_dat = div16[7:0];
      default:    bus.o_dat = div16[15:8];
    endcase
  end

  // Frame shifter; format and divisor are frozen in shadow registers at load.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    div_sh_d   = div_sh_q;
    baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_W'(1);
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        state_d    = ST_START;
        shift_d    = fifo_rdata;
        par_d      = ctrl_q[CTRL_PAR_LSB +: 2];
        stop2_d    = ctrl_q[CTRL_STOP2];
        div_sh_d   = div_q;
        baud_cnt_d = '0;
      end
      ST_START: if (tick) begin
        state_d   = ST_DATA;
        bit_idx_d = 3'd0;
      end
      ST_DATA: if (tick) begin
        if (bit_idx_q == 3'd7) state_d = par_enabled(par_q) ? ST_PARITY : ST_STOP1;
        else                   bit_idx_d = bit_idx_q + 3'd1;
      end
      ST_PARITY: if (tick) state_d = ST_STOP1;
      ST_STOP1:  if (tick) state_d = stop2_q ? ST_STOP2 : ST_DONE;
      ST_STOP2:  if (tick) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift_q[bit_idx_q];
      ST_PARITY: tx = (par_q == PAR_ODD) ? ~^shift_q : ^shift_q;
      default:   tx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      div_q      <= DIV_W'(DIV_RST);
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      div_q      <= div_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q  <= shift_d;
    par_q    <= par_d;
    stop2_q  <= stop2_d;
    div_sh_q <= div_sh_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: per-cycle tx/o_int streams are
// compared against a frame-level model built from bytes and format settings.
module tb_uart_tx_fifo;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic tx, o_int;

  int errors = 0;
  int checks = 0;

  logic       rec = 1'b0;
  logic [1:0] obs_q[$];
  logic [1:0] exp_q[$];

  uart_tx_fifo_if bus();

  uart_tx_fifo #(
    .SYS_CLK(25_000_000), .BAUDRATE(115_200), .FIFO_DEPTH(16), .DIV_W(16)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus),
    .tx     (tx),
    .o_int  (o_int)
  );

  always #5 i_clk = ~i_clk;

  // Monitor: one {tx,o_int} sample per cycle, 1 ns after the edge.
  always @(posedge i_clk) begin
    #1;
    if (rec) obs_q.push_back({tx, o_int});
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic bus_write(input logic [1:0] adr, input logic [7:0] dat);
    bus.i_cyc = 1'b1; bus.i_we = 1'b1; bus.i_adr = adr; bus.i_dat = dat;
    @(posedge i_clk); #1;
    bus.i_cyc = 1'b0; bus.i_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] adr, output logic [7:0] dat);
    bus.i_adr = adr;
    #1;
    dat = bus.o_dat;
  endtask

  // Expected line activity, one entry per cycle starting at the cycle after
  // the first data write: one idle cycle, then each frame at (div+1) cycles
  // per bit, a completion cycle, and an idle cycle before the next frame.
  task automatic model_frames(input logic [7:0] bytes[$], input logic [6:0] ctrl, input int div);
    logic bits[$];
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(2'b10);
    for (int j = 0; j < bytes.size(); j++) begin
      b = bytes[j];
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (ctrl[1:0] == 2'b01) bits.push_back(($countones(b) % 2) == 1);
      if (ctrl[1:0] == 2'b10) bits.push_back(($countones(b) % 2) == 0);
      bits.push_back(1'b1);
      if (ctrl[2]) bits.push_back(1'b1);
      foreach (bits[k]) repeat (div + 1) exp_q.push_back({bits[k], 1'b0});
      exp_q.push_back({1'b1, (j == bytes.size() - 1) && !ctrl[3]});
      if (j != bytes.size() - 1) exp_q.push_back(2'b10);
    end
    repeat (6) exp_q.push_back(2'b10);
  endtask

  task automatic capture_wait();
    for (int c = 0; c < exp_q.size() + 50 && obs_q.size() < exp_q.size(); c++) @(posedge i_clk);
    #2;
    rec = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    bus.i_cyc = 1'b0; bus.i_we = 1'b0; bus.i_adr = 2'd0; bus.i_dat = 8'h00;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", o_int); end
    bus_read(2'd0, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL reset_status got %h exp 04", d); end
    bus_read(2'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", d); end
    bus_read(2'd2, d);
    checks++; if (d !== 8'hD8) begin errors++; $display("FAIL reset_div_lo got %h exp d8", d); end
    bus_read(2'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_div_hi got %h exp 00", d); end
  endtask

  task automatic test_default_frame();
    logic [7:0] bytes[$];
    logic [7:0] d;
    int bad, first, pulses;
    bytes = '{8'h55};
    model_frames(bytes, 7'h00, 216);
    obs_q.delete(); rec = 1'b1;
    bus_write(2'd0, 8'h55);
    capture_wait();
    bad = 0; first = -1; pulses = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin bad++; if (first < 0) first = k; end
      if (k < obs_q.size() && obs_q[k][0] === 1'b1) pulses++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL default_stream got %0d bad cycles (first %0d) exp 0", bad, first); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL default_int_count got %0d exp 1", pulses); end
    bus_read(2'd0, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL default_idle_status got %h exp 04", d); end
  endtask

  task automatic test_parity();
    logic [7:0] bytes[$];
    int bad, first;
    bus_write(2'd2, 8'd3);
    bus_write(2'd3, 8'd0);
    bus_write(2'd1, 8'h01);
    bytes = '{8'h07};
    model_frames(bytes, 7'h01, 3);
    obs_q.delete(); rec = 1'b1;
    bus_write(2'd0, 8'h07);
    capture_wait();
    bad = 0; first = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin bad++; if (first < 0) first = k; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL even_parity_stream got %0d bad cycles (first %0d) exp 0", bad, first); end

    bus_write(2'd1, 8'h06);
    bytes = '{8'h00};
    model_frames(bytes, 7'h06, 3);
    obs_q.delete(); rec = 1'b1;
    bus_write(2'd0, 8'h00);
    capture_wait();
    bad = 0; first = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin bad++; if (first < 0) first = k; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL odd_2stop_stream got %0d bad cycles (first %0d) exp 0", bad, first); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[$];
    logic [7:0] d;
    int bad, first;
    bus_write(2'd1, 8'h00);
    bytes.delete();
    for (int i = 0; i < 17; i++) bytes.push_back(8'(i));
    model_frames(bytes, 7'h00, 3);
    obs_q.delete(); rec = 1'b1;
    for (int i = 0; i < 18; i++) bus_write(2'd0, 8'(i));
    bus_read(2'd0, d);
    checks++; if (d !== 8'h0B) begin errors++; $display("FAIL b2b_full_status got %h exp 0b", d); end
    capture_wait();
    bad = 0; first = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin bad++; if (first < 0) first = k; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_stream got %0d bad cycles (first %0d) exp 0", bad, first); end
    bus_read(2'd0, d);
    checks++; if (d !== 8'h0C) begin errors++; $display("FAIL b2b_overflow_status got %h exp 0c", d); end
    bus_write(2'd1, 8'h80);
    bus_read(2'd0, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL ovf_clear_status got %h exp 04", d); end
    bus_read(2'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovf_clear_ctrl got %h exp 00", d); end
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    logic [7:0] d;
    logic [6:0] ctrl;
    int div, n, bad, first;
    for (int it = 0; it < 5; it++) begin
      div  = $urandom_range(0, 4);
      ctrl = 7'($urandom_range(0, 15));
      n    = $urandom_range(1, 4);
      bytes.delete();
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
      bus_write(2'd2, 8'(div));
      bus_write(2'd3, 8'd0);
      bus_write(2'd1, {1'b0, ctrl});
      bus_read(2'd1, d);
      checks++; if (d !== {1'b0, ctrl}) begin errors++; $display("FAIL rand_ctrl_rb it=%0d got %h exp %h", it, d, {1'b0, ctrl}); end
      model_frames(bytes, ctrl, div);
      obs_q.delete(); rec = 1'b1;
      for (int i = 0; i < n; i++) bus_write(2'd0, bytes[i]);
      capture_wait();
      bad = 0; first = -1;
      for (int k = 0; k < exp_q.size(); k++)
        if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin bad++; if (first < 0) first = k; end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL rand_stream it=%0d div=%0d ctrl=%h n=%0d got %0d bad cycles (first %0d) exp 0", it, div, ctrl, n, bad, first);
      end
    end
    bus_write(2'd1, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] bytes[$];
    logic [7:0] d;
    int bad, first, pulses;
    bus_write(2'd2, 8'd3);
    bus_write(2'd3, 8'd0);
    bus_write(2'd1, 8'h00);
    bus_write(2'd0, 8'hA5);
    repeat (18) @(posedge i_clk);
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_frame_bit3 got %b exp 0", tx); end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_abort_tx got %b exp 1", tx); end
    checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL reset_abort_int got %b exp 0", o_int); end
    i_reset = 1'b0;
    bus_read(2'd0, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL reset_abort_status got %h exp 04", d); end
    pulses = 0;
    repeat (60) begin
      @(posedge i_clk); #1;
      if (o_int === 1'b1 || tx !== 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_abort_quiet got %0d active cycles exp 0", pulses); end

    bus_write(2'd2, 8'd3);
    bytes = '{8'h3C};
    model_frames(bytes, 7'h00, 3);
    obs_q.delete(); rec = 1'b1;
    bus_write(2'd0, 8'h3C);
    capture_wait();
    bad = 0; first = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin bad++; if (first < 0) first = k; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL post_reset_stream got %0d bad cycles (first %0d) exp 0", bad, first); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_parity();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered, runtime-configurable UART transmitter and bus slave, the next generation of the single-byte transmitter.
- Bytes written over the 8-bit bus are queued in a FIFO and serialised LSB-first: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Baud divisor and frame format are software-programmable.
- o_int pulses once when the queue drains and the last frame completes.
- Sits on the system bus beside the UART RX block and feeds the board tx pin.

Parameters:
SYS_CLK, 25_000_000, system clock frequency in Hz.
BAUDRATE, 115_200, baud rate used to compute the divisor reset value DIV_RST = SYS_CLK/BAUDRATE - 1.
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
DIV_W, 16, width of the baud divisor register.

Ports:
i_clk  in  1  system clock; the block's only clock.
i_reset  in  1  synchronous, active-high reset.
i_adr  in  2  register select: 0 DATA/STATUS, 1 CTRL, 2 DIV_LO, 3 DIV_HI.
i_dat  in  8  write data.
o_dat  out  8  read data, combinational from i_adr.
i_we  in  1  write strobe, qualified by i_cyc.
i_cyc  in  1  bus cycle active.
tx  out  1  serial output; idle high.
o_int  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - tx=1, o_int=0, FIFO emptied, shifter IDLE, overflow=0.
  - CTRL=0: no parity, 1 stop bit, interrupt enabled.
  - divisor=DIV_RST[DIV_W-1:0].
- Writes (i_cyc & i_we):
  - adr0 pushes i_dat. If the FIFO is full (registered count), the byte is dropped and sticky overflow is set. A pop in the same cycle does not rescue it.
  - adr1 CTRL bits:
    - [1:0] parity: 00 none, 01 even, 10 odd, 11 none.
    - [2] two stop bits.
    - [3] interrupt disable.
    - [7] write-1 clears overflow; not stored.
  - adr2/adr3 write divisor[7:0] / divisor[15:8]. Bits at or above DIV_W are ignored.
- Reads:
  - adr0 STATUS: {4'b0, overflow, empty, full, busy}. busy = shifter not IDLE or FIFO non-empty.
  - adr1 returns CTRL with bit7 = 0.
  - adr2/adr3 return the divisor bytes.
  - Reads have no side effects.
- Baud counter:
  - Cleared on frame load; otherwise increments.
  - tick when counter == divisor; the counter clears on tick.
  - Bit period = divisor+1 cycles. divisor=0 gives 1 cycle per bit.
- Frame load: when the shifter is IDLE and the FIFO is non-empty, pop the head and latch data, CTRL and divisor into shadow registers. Register writes mid-frame affect only the next frame.
- Latency: a write at edge N makes the FIFO non-empty after N; the pop and load happen at edge N+1; tx goes low from N+1 (start bit).
- States: IDLE, START, DATA (3-bit index 0..7), PARITY, STOP1, STOP2, DONE.
  - IDLE→START on load.
  - START→DATA(0) on tick.
  - DATA(i)→DATA(i+1) on tick; DATA(7)→PARITY on tick if parity enabled, else →STOP1.
  - PARITY→STOP1 on tick.
  - STOP1→STOP2 on tick if two stop bits, else →DONE.
  - STOP2→DONE on tick.
  - DONE→IDLE in one cycle.
- tx per state: START=0; DATA=data[i]; PARITY=^data (even) or ~^data (odd); all others 1.
- o_int = (state==DONE) & FIFO empty & ~int-disable. Back-to-back frames raise no interrupt until the final frame completes.
- FIFO: binary read/write pointers with wrap at FIFO_DEPTH, plus a count register of width clog2(FIFO_DEPTH)+1. full = (count==FIFO_DEPTH). Simultaneous push and pop when not full and not empty keep the count unchanged.
- Reset mid-frame: tx=1 on the following cycle, the frame is aborted, the FIFO is flushed and no o_int is generated.

Decomposition:
- Package uart_pkg holds:
  - shifter state encoding;
  - register addresses ADR_DATA, ADR_CTRL, ADR_DIV_LO, ADR_DIV_HI;
  - CTRL bit positions and parity mode constants.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count. It is shared with the future RX block.

Test Plan:
- Reset defaults: read STATUS -> 0x04 (empty); read DIV_LO/DIV_HI -> 0xD8/0x00 (216); tx=1, o_int=0.
- Write 0x55, default format -> tx low 217 cycles, then bits 1,0,1,0,1,0,1,0 at 217 cycles each, stop high. o_int pulses once exactly 10*217 cycles after tx falls; busy=0 afterwards.
- DIV=3, CTRL=0x01 (even parity), write 0x07 -> 4-cycle bits: start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1; frame 44 cycles.
- DIV=3, CTRL=0x06 (odd parity, 2 stop), write 0x00 -> parity bit 1; two 4-cycle stop bits; frame 48 cycles.
- 18 back-to-back writes 0x00..0x11 (depth 16) -> the first is popped immediately, 16 are queued, 0x11 is dropped and overflow=1. All 17 accepted bytes transmit in order with a single o_int at the end. Writing CTRL bit7 clears overflow.
- Reset asserted mid-DATA bit 3 -> tx=1 next cycle, STATUS=0x04, no o_int; a subsequent write transmits normally.
